// File: rtl/ysyx_23060077_if_id_fifo_pkg.sv
// Shared opcode constants and helpers for the fetch/decode instruction buffer.
package ysyx_23060077_if_id_fifo_pkg;

   // Major opcodes and function codes used by enqueue-time predecode.
   localparam logic [6:0] OPC_JAL        = 7'b1101111;
   localparam logic [6:0] OPC_JALR       = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
   localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
   localparam logic [2:0] FUNCT3_FENCE_I = 3'b001;

   // True when the opcode redirects control flow (jal, jalr, conditional branch).
   function automatic logic is_ctrl_flow_opc(input logic [6:0] opcode);
      return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/ysyx_23060077_predecode.sv
// Combinational predecode: flags control-flow instructions and fence.i.
module ysyx_23060077_predecode
   import ysyx_23060077_if_id_fifo_pkg::*;
#(
   parameter int INST_WIDTH = 32
) (
   input  logic [INST_WIDTH-1:0] inst,
   output logic                  ctrl_flow,
   output logic                  fence_i
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_upper_bits;

   // Only the opcode and funct3 fields matter for these two flags.
   assign unused_upper_bits = ^inst[INST_WIDTH-1:15];

   // Extract fields and classify the instruction.
   always_comb begin
      opcode    = inst[6:0];
      funct3    = inst[14:12];
      ctrl_flow = is_ctrl_flow_opc(opcode);
      fence_i   = (opcode == OPC_MISC_MEM) && (funct3 == FUNCT3_FENCE_I);
   end

endmodule

// File: rtl/ysyx_23060077_if_id_fifo.sv
// First-word-fall-through instruction buffer between fetch and decode.
// Ready depends only on registered occupancy, so id_ready_i never reaches
// if_to_id_ready_o combinationally. A redirect empties the queue.
module ysyx_23060077_if_id_fifo
   import ysyx_23060077_if_id_fifo_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic                         if_to_id_valid_i,
   output logic                         if_to_id_ready_o,
   input  logic [DATA_WIDTH-1:0]        ifu_pc_i,
   input  logic [INST_WIDTH-1:0]        ifu_inst_i,
   output logic                         id_valid_o,
   input  logic                         id_ready_i,
   output logic [DATA_WIDTH-1:0]        id_pc_o,
   output logic [INST_WIDTH-1:0]        id_inst_o,
   output logic                         id_ctrl_flow_o,
   output logic                         id_fence_i_o,
   output logic [$clog2(DEPTH+1)-1:0]   id_count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] pc_mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_d   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
   logic                  cf_mem_q   [DEPTH];
   logic                  cf_mem_d   [DEPTH];
   logic                  fi_mem_q   [DEPTH];
   logic                  fi_mem_d   [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic enq;
   logic deq;
   logic pre_ctrl_flow;
   logic pre_fence_i;

   // Classify the incoming instruction so decode gets the flags for free.
   ysyx_23060077_predecode #(
      .INST_WIDTH (INST_WIDTH)
   ) u_predecode (
      .inst      (ifu_inst_i),
      .ctrl_flow (pre_ctrl_flow),
      .fence_i   (pre_fence_i)
   );

   // Status and head outputs come straight from registered state.
   always_comb begin
      if_to_id_ready_o = (count_q != FULL_COUNT);
      id_valid_o       = (count_q != '0);
      id_pc_o          = pc_mem_q[rd_ptr_q];
      id_inst_o        = inst_mem_q[rd_ptr_q];
      id_ctrl_flow_o   = cf_mem_q[rd_ptr_q];
      id_fence_i_o     = fi_mem_q[rd_ptr_q];
      id_count_o       = count_q;
   end

   // Next-state for storage, pointers and occupancy; flush overrides both sides.
   always_comb begin
      enq        = if_to_id_valid_i & if_to_id_ready_o & ~flush_i;
      deq        = id_valid_o & id_ready_i;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      cf_mem_d   = cf_mem_q;
      fi_mem_d   = fi_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            pc_mem_d[wr_ptr_q]   = ifu_pc_i;
            inst_mem_d[wr_ptr_q] = ifu_inst_i;
            cf_mem_d[wr_ptr_q]   = pre_ctrl_flow;
            fi_mem_d[wr_ptr_q]   = pre_fence_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset clears every entry so the head reads as zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
            cf_mem_q[i]   <= 1'b0;
            fi_mem_q[i]   <= 1'b0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
         cf_mem_q   <= cf_mem_d;
         fi_mem_q   <= fi_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060077_if_id_fifo.sv
// Directed bench for the fetch/decode instruction buffer with a queue model.
module tb_ysyx_23060077_if_id_fifo;

   localparam int DEPTH = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush_i;
   logic        if_to_id_valid_i;
   logic        if_to_id_ready_o;
   logic [31:0] ifu_pc_i;
   logic [31:0] ifu_inst_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_ctrl_flow_o;
   logic        id_fence_i_o;
   logic [1:0]  id_count_o;

   int checks   = 0;
   int failures = 0;
   bit model_en = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;
   ent_t mq[$];

   ysyx_23060077_if_id_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (32),
      .INST_WIDTH (32)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .flush_i          (flush_i),
      .if_to_id_valid_i (if_to_id_valid_i),
      .if_to_id_ready_o (if_to_id_ready_o),
      .ifu_pc_i         (ifu_pc_i),
      .ifu_inst_i       (ifu_inst_i),
      .id_valid_o       (id_valid_o),
      .id_ready_i       (id_ready_i),
      .id_pc_o          (id_pc_o),
      .id_inst_o        (id_inst_o),
      .id_ctrl_flow_o   (id_ctrl_flow_o),
      .id_fence_i_o     (id_fence_i_o),
      .id_count_o       (id_count_o)
   );

   always #5 clock = ~clock;

   function automatic bit exp_cf(input logic [31:0] inst);
      return inst[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011};
   endfunction

   function automatic bit exp_fi(input logic [31:0] inst);
      return (inst[6:0] == 7'b0001111) && (inst[14:12] == 3'b001);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
      end else begin
         $display("ok   %s value=0x%0h @%0t", name, act, $time);
      end
   endtask

   // Reference model: a queue of accepted entries, updated on each edge.
   always @(posedge clock) begin
      bit full_now, empty_now;
      full_now  = (mq.size() == DEPTH);
      empty_now = (mq.size() == 0);
      if (reset || flush_i) begin
         mq.delete();
      end else begin
         if (!empty_now && id_ready_i) void'(mq.pop_front());
         if (!full_now && if_to_id_valid_i) mq.push_back('{pc: ifu_pc_i, inst: ifu_inst_i});
      end
   end

   // Compare DUT against the model on the falling edge, between drive and sample.
   always @(negedge clock) begin
      if (model_en) begin
         check("m_valid", id_valid_o, mq.size() != 0);
         check("m_ready", if_to_id_ready_o, mq.size() != DEPTH);
         check("m_count", id_count_o, mq.size());
         if (mq.size() != 0) begin
            check("m_pc",   id_pc_o,   mq[0].pc);
            check("m_inst", id_inst_o, mq[0].inst);
            check("m_cf",   id_ctrl_flow_o, exp_cf(mq[0].inst));
            check("m_fi",   id_fence_i_o,   exp_fi(mq[0].inst));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, id_valid_o, 0);
      check({tag, "_ready"}, if_to_id_ready_o, 1);
      check({tag, "_count"}, id_count_o, 0);
      check({tag, "_pc"},    id_pc_o, 0);
      check({tag, "_inst"},  id_inst_o, 0);
      check({tag, "_cf"},    id_ctrl_flow_o, 0);
      check({tag, "_fi"},    id_fence_i_o, 0);
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
      if_to_id_valid_i = 1'b1;
      ifu_pc_i         = pc;
      ifu_inst_i       = inst;
   endtask

   logic [31:0] pd_inst [4] = '{32'h0000_006F, 32'h0000_100F, 32'h0000_8067, 32'h0000_0063};
   logic        pd_cf   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic        pd_fi   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      reset = 1'b1; flush_i = 1'b0; if_to_id_valid_i = 1'b0;
      ifu_pc_i = '0; ifu_inst_i = '0; id_ready_i = 1'b0;
      step(); step();
      reset = 1'b0;
      check_reset_state("rst");
      model_en = 1'b1;

      // Single enqueue, visible one cycle later.
      offer(32'h3000_0000, 32'h0000_0013);
      step();
      check("single_valid", id_valid_o, 1);
      check("single_pc", id_pc_o, 32'h3000_0000);
      check("single_cf", id_ctrl_flow_o, 0);
      check("single_count", id_count_o, 1);

      // Fill, then a third offer must be refused; no pass-through when full.
      offer(32'h3000_0004, 32'h0000_0013);
      step();
      check("full_ready", if_to_id_ready_o, 0);
      check("full_count", id_count_o, 2);
      offer(32'h3000_0008, 32'h0000_0013);
      id_ready_i = 1'b1;
      step();
      if_to_id_valid_i = 1'b0;
      check("drain0_pc", id_pc_o, 32'h3000_0004);
      check("drain0_count", id_count_o, 1);
      step();
      check("drain1_valid", id_valid_o, 0);

      // Streaming: one in, one out per cycle.
      for (int k = 0; k < 10; k++) begin
         offer(32'h4000_0000 + 32'(4 * k), 32'h0000_0013 + 32'(k << 7));
         step();
         check("stream_pc", id_pc_o, 32'h4000_0000 + 32'(4 * k));
         check("stream_count", id_count_o, 1);
      end
      if_to_id_valid_i = 1'b0;
      step();
      check("stream_end_valid", id_valid_o, 0);

      // Flush with two entries and a concurrent offer.
      id_ready_i = 1'b0;
      offer(32'h5000_0000, 32'h0000_006F);
      step();
      offer(32'h5000_0004, 32'h0000_0013);
      step();
      flush_i = 1'b1;
      offer(32'h5000_0008, 32'h0000_0013);
      id_ready_i = 1'b1;
      step();
      flush_i = 1'b0;
      if_to_id_valid_i = 1'b0;
      check("flush_valid", id_valid_o, 0);
      check("flush_count", id_count_o, 0);
      check("flush_ready", if_to_id_ready_o, 1);
      step();
      check("flush_later_valid", id_valid_o, 0);

      // Predecode of representative instructions.
      for (int k = 0; k < 4; k++) begin
         id_ready_i = 1'b0;
         offer(32'h6000_0000 + 32'(4 * k), pd_inst[k]);
         step();
         if_to_id_valid_i = 1'b0;
         check("pd_cf", id_ctrl_flow_o, pd_cf[k]);
         check("pd_fi", id_fence_i_o, pd_fi[k]);
         id_ready_i = 1'b1;
         step();
      end

      // Reset while full.
      id_ready_i = 1'b0;
      offer(32'h7000_0000, 32'h0000_100F);
      step();
      offer(32'h7000_0004, 32'h0000_006F);
      step();
      if_to_id_valid_i = 1'b0;
      check("pre_rst_ready", if_to_id_ready_o, 0);
      check("pre_rst_fi", id_fence_i_o, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_state("rst_full");
      step();
      model_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_23060077_if_id_fifo.md
# ysyx_23060077_if_id_fifo

Instruction buffer between the fetch stage (`ysyx_23060077_ifu`) and the decode stage (`ysyx_23060077_idu`). It accepts fetched `{pc, inst}` pairs on the `if_to_id` valid/ready handshake and holds up to DEPTH entries in a first-word-fall-through queue. It predecodes control-flow and `fence.i` at enqueue, and discards all contents on a redirect. It decouples Icache latency from decode stalls and has no combinational path from `id_ready_i` to `if_to_id_ready_o`.

## Interface
- `DEPTH`, 2: entry count; power of two, ≥2
- `DATA_WIDTH`, 32: pc width (`` `DATA_WIDTH ``)
- `INST_WIDTH`, 32: instruction width (`` `INST_WIDTH ``)

- `clock`  in  1  sole clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `flush_i`  in  1  redirect (driven by `jump_pc_valid`); discards all entries
- `if_to_id_valid_i`  in  1  fetch entry valid
- `if_to_id_ready_o`  out  1  buffer can accept
- `ifu_pc_i`  in  DATA_WIDTH  fetched pc
- `ifu_inst_i`  in  INST_WIDTH  fetched instruction
- `id_valid_o`  out  1  head entry valid
- `id_ready_i`  in  1  decode accepts head
- `id_pc_o`  out  DATA_WIDTH  head pc
- `id_inst_o`  out  INST_WIDTH  head instruction
- `id_ctrl_flow_o`  out  1  head is jal/jalr/branch
- `id_fence_i_o`  out  1  head is `fence.i`
- `id_count_o`  out  $clog2(DEPTH+1)  current occupancy

## Operation
- **Storage:** DEPTH × {pc, inst, ctrl_flow, fence_i} registers; `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally; `count` is $clog2(DEPTH+1) bits.
- **Enqueue:** `enq = if_to_id_valid_i & if_to_id_ready_o & !flush_i`. Writes `mem[wr_ptr]` and increments `wr_ptr`.
- **Dequeue:** `deq = id_valid_o & id_ready_i`. Increments `rd_ptr`.
- **Count update:** `count += enq - deq`. Simultaneous enq and deq leaves count unchanged.
- **Status outputs:**
  - `if_to_id_ready_o = (count != DEPTH)`, a function of registered state only.
  - `id_valid_o = (count != 0)`.
  - `id_*` fields are driven from `mem[rd_ptr]`.
- **Predecode at enqueue:**
  - ctrl_flow = `opcode[6:0] ∈ {1101111, 1100111, 1100011}`.
  - fence_i = `opcode == 0001111 && inst[14:12] == 3'b001`.
- **Flush:** has priority over enq and deq. Next cycle `count = 0`, `wr_ptr = rd_ptr = 0`. A deq handshake in the flush cycle still counts as consumed by decode. An upstream entry offered in the flush cycle is dropped.
- **Full:** ready low, no pass-through even if `id_ready_i = 1`.
- **Empty:** `id_*` fields are don't-care (they show the stale `mem[rd_ptr]`), and `id_valid_o = 0`.

## Timing
- **Latency:** entry enqueued at edge N is visible as head with `id_valid_o = 1` after edge N (1 cycle).
- **Throughput:** 1 entry/cycle in steady state with `id_ready_i` held high.
- **Reset values:**
  - `id_valid_o = 0`, `if_to_id_ready_o = 1` (count 0).
  - All mem fields 0, so `id_pc_o = id_inst_o = 0` and `id_ctrl_flow_o = id_fence_i_o = 0`.
  - `id_count_o = 0`.
- **Reset mid-operation:** identical to flush; contents are lost.
- **Holding rule:** head fields stay stable while `id_valid_o & !id_ready_i`.
- **Upstream rule:** `ifu_pc_i`/`ifu_inst_i` are sampled only on the enq edge. Upstream may hold valid across cycles; each accepted cycle is a distinct entry.

## Structure
- Opcode constants `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_MISC_MEM` and `FUNCT3_FENCE_I` are added to `ysyx_23060077_define.v`.
- One combinational sub-module, `ysyx_23060077_predecode`:
  - input `inst`;
  - outputs `ctrl_flow`, `fence_i`;
  - reused by later decode work.
- The queue and pointer logic stay in the top module.

## Test plan
- **Reset then single enqueue:** pc=0x3000_0000, inst=0x0000_0013. Next cycle `id_valid_o=1`, `id_pc_o=0x3000_0000`, `id_ctrl_flow_o=0`, `id_count_o=1`.
- **Fill with id_ready_i=0:** enqueue 0x3000_0000 and 0x3000_0004 (DEPTH=2). `if_to_id_ready_o=0`, third offer not accepted. Raise `id_ready_i`: heads appear in order 0x…00, 0x…04.
- **Streaming:** valid_i and id_ready_i both high for 10 cycles. 10 entries out in order, `id_count_o` constant at 1 after the first cycle.
- **Flush with 2 entries plus concurrent offer:** next cycle `id_valid_o=0`, `id_count_o=0`, ready=1. The offered entry never appears.
- **Predecode:**
  - inst 0x0000006F (jal) → `ctrl_flow=1`.
  - inst 0x0000100F (fence.i) → `fence_i=1`, `ctrl_flow=0`.
  - inst 0x00008067 (jalr) → `ctrl_flow=1`.
- **Reset asserted while full:** next cycle all outputs at reset values, `if_to_id_ready_o=1`.
